// File: rtl/canvas_pkg.sv
// Shared constants, types and FSM encoding for the 28x28 drawing canvas writer.
package canvas_pkg;

   localparam int GRID      = 28;
   localparam int CELL_PX   = 14;
   localparam int CANVAS_X0 = 199;
   localparam int CANVAS_Y0 = 43;

   localparam logic [15:0] CENTER_INK = 16'h07F8;
   localparam logic [15:0] EDGE_INK   = 16'h0300;
   localparam logic [15:0] INK_MAX    = 16'h07F8;

   typedef logic [15:0] cell_t;
   typedef cell_t [GRID-1:0][GRID-1:0] canvas_t;

   typedef enum logic [2:0] {
      IDLE, S_CENTER, S_UP, S_DOWN, S_LEFT, S_RIGHT, CLEAR
   } state_t;

   // Saturating add; the 17-bit sum guarantees no wrap before the clamp.
   function automatic cell_t ink_add(input cell_t old, input cell_t ink);
      logic [16:0] s;
      s = {1'b0, old} + {1'b0, ink};
      return (s > {1'b0, INK_MAX}) ? INK_MAX : s[15:0];
   endfunction

endpackage

// File: rtl/canvas_cell_index.sv
// Screen coordinate -> canvas cell index by comparison against multiples of
// CELL_PX above the origin, avoiding a divider.
module canvas_cell_index
   import canvas_pkg::*;
#(
   parameter int ORIGIN = 0
) (
   input  logic [9:0] coord_i,
   output logic [4:0] idx_o,
   output logic       valid_o
);

   int c;

   always_comb begin
      c     = int'({22'd0, coord_i});
      idx_o = '0;
      for (int k = 1; k < GRID; k++) begin
         if (c >= ORIGIN + k * CELL_PX) idx_o = 5'(k);
      end
      valid_o = (c >= ORIGIN) && (c < ORIGIN + GRID * CELL_PX);
   end

endmodule

// File: rtl/canvas_painter.sv
// Canvas writer: turns sampled cursor/button state into 5-cell brush strokes
// (one read-modify-write per cycle) and clears the canvas one row per cycle.
module canvas_painter
   import canvas_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [9:0] BallX,
   input  logic [9:0] BallY,
   input  logic       draw,
   input  logic       clear_req,
   output canvas_t    canvas,
   output logic       busy,
   output logic       done,
   output logic       dirty
);

   logic [4:0] cx_w, cy_w;
   logic       vx_w, vy_w;

   canvas_cell_index #(.ORIGIN(CANVAS_X0)) u_idx_x (
      .coord_i (BallX),
      .idx_o   (cx_w),
      .valid_o (vx_w)
   );

   canvas_cell_index #(.ORIGIN(CANVAS_Y0)) u_idx_y (
      .coord_i (BallY),
      .idx_o   (cy_w),
      .valid_o (vy_w)
   );

   state_t     state_q;
   canvas_t    canvas_q;
   logic [4:0] cx_q, cy_q, row_q;
   logic       pend_q, busy_q, done_q, dirty_q;

   logic [4:0] tgt_x, tgt_y;
   logic       wr_en;
   cell_t      ink, cell_d;

   // Target cell for this stroke state; off-grid neighbours leave the target
   // on the centre cell (always in range) and simply suppress the write.
   always_comb begin
      tgt_x = cx_q;
      tgt_y = cy_q;
      wr_en = 1'b0;
      ink   = EDGE_INK;
      unique case (state_q)
         S_CENTER: begin
            wr_en = 1'b1;
            ink   = CENTER_INK;
         end
         S_UP: if (cy_q != 5'd0) begin
            wr_en = 1'b1;
            tgt_y = cy_q - 5'd1;
         end
         S_DOWN: if (cy_q != 5'(GRID-1)) begin
            wr_en = 1'b1;
            tgt_y = cy_q + 5'd1;
         end
         S_LEFT: if (cx_q != 5'd0) begin
            wr_en = 1'b1;
            tgt_x = cx_q - 5'd1;
         end
         S_RIGHT: if (cx_q != 5'(GRID-1)) begin
            wr_en = 1'b1;
            tgt_x = cx_q + 5'd1;
         end
         default: ;
      endcase
      cell_d = ink_add(canvas_q[tgt_x][tgt_y], ink);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= IDLE;
         canvas_q <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         row_q    <= '0;
         pend_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dirty_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (wr_en) canvas_q[tgt_x][tgt_y] <= cell_d;
         // A clear arriving mid-stroke is remembered; one arriving mid-clear is absorbed.
         if (clear_req && state_q != IDLE && state_q != CLEAR) pend_q <= 1'b1;

         unique case (state_q)
            IDLE: begin
               if (clear_req || pend_q) begin
                  state_q <= CLEAR;
                  row_q   <= '0;
                  pend_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (frame_tick && draw && vx_w && vy_w) begin
                  cx_q    <= cx_w;
                  cy_q    <= cy_w;
                  state_q <= S_CENTER;
                  busy_q  <= 1'b1;
               end
            end
            S_CENTER: begin
               dirty_q <= 1'b1;
               state_q <= S_UP;
            end
            S_UP:   state_q <= S_DOWN;
            S_DOWN: state_q <= S_LEFT;
            S_LEFT: state_q <= S_RIGHT;
            S_RIGHT: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            CLEAR: begin
               for (int x = 0; x < GRID; x++) canvas_q[x][row_q] <= '0;
               if (row_q == 5'(GRID-1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  dirty_q <= 1'b0;
               end else begin
                  row_q <= row_q + 5'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign canvas = canvas_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign dirty  = dirty_q;

endmodule
